// File: rtl/p2m_echo_request_deser.sv
// -----------------------------------------------------------------------------
// p2m_echo_request_deser
//
// Purpose:
//   Receive side of the echo link. Takes a 32-bit word-serial pipe stream,
//   parses a header word plus payload words and issues exactly one
//   EchoRequest method call (say / say2 / say4) per legal message.
//   Unknown or malformed messages are drained and counted in a saturating
//   error counter.
//
// Header word: [31:16] method id, [15:0] total length in words incl. header.
//   id 0 say  len 2 : word1 = v
//   id 1 say2 len 2 : word1 = {a, b}
//   id 2 say4 len 5 : words1..4 = a, b, c, d
//
// Ports:
//   i_clk            clock, all state changes on the rising edge
//   i_rst            synchronous reset, active-high
//   i_pipe_enq_ena   word valid from transport
//   i_pipe_enq_v     word data
//   o_pipe_enq_rdy   deserializer can take a word
//   o_say_ena        call say(v)            o_say_v        say argument
//   i_say_rdy        say callee ready
//   o_say2_ena       call say2(a,b)         o_say2_a/_b    16-bit arguments
//   i_say2_rdy       say2 callee ready
//   o_say4_ena       call say4(a,b,c,d)     o_say4_a.._d   32-bit arguments
//   i_say4_rdy       say4 callee ready
//   o_err_count      saturating count of dropped messages
// -----------------------------------------------------------------------------
module p2m_echo_request_deser #(
    parameter int MAX_WORDS = 8,
    parameter int ERR_W     = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pipe_enq_ena,
    input  logic [31:0]      i_pipe_enq_v,
    output logic             o_pipe_enq_rdy,
    output logic             o_say_ena,
    output logic [31:0]      o_say_v,
    input  logic             i_say_rdy,
    output logic             o_say2_ena,
    output logic [15:0]      o_say2_a,
    output logic [15:0]      o_say2_b,
    input  logic             i_say2_rdy,
    output logic             o_say4_ena,
    output logic [31:0]      o_say4_a,
    output logic [31:0]      o_say4_b,
    output logic [31:0]      o_say4_c,
    output logic [31:0]      o_say4_d,
    input  logic             i_say4_rdy,
    output logic [ERR_W-1:0] o_err_count
);

    typedef enum logic [1:0] {
        S_HDR,
        S_PAY,
        S_DISPATCH,
        S_DRAIN
    } state_t;

    localparam logic [1:0] ID_SAY  = 2'd0;
    localparam logic [1:0] ID_SAY2 = 2'd1;
    localparam logic [1:0] ID_SAY4 = 2'd2;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_id;
    logic [1:0]        r_lenm1;
    logic [15:0]       r_remaining;
    logic [31:0]       r_pay [4];
    logic [ERR_W-1:0]  r_err;

    logic              w_accept;
    logic [15:0]       w_hdr_id;
    logic [15:0]       w_hdr_len;
    logic [15:0]       w_hdr_lenm1;
    logic              w_hdr_short;
    logic              w_hdr_legal;
    logic [1:0]        w_slot;
    logic              w_err_inc;

    assign o_pipe_enq_rdy = (r_state != S_DISPATCH);
    assign w_accept       = i_pipe_enq_ena & o_pipe_enq_rdy;

    assign w_hdr_id    = i_pipe_enq_v[31:16];
    assign w_hdr_len   = i_pipe_enq_v[15:0];
    assign w_hdr_lenm1 = w_hdr_len - 16'd1;
    assign w_hdr_short = (w_hdr_len <= 16'd1);

    // Legal messages have fixed lengths; the MAX_WORDS bound still applies
    // in case the block is built with a smaller limit.
    always_comb begin
        w_hdr_legal = 1'b0;
        if (w_hdr_len <= 16'(MAX_WORDS)) begin
            case (w_hdr_id)
                16'd0:   w_hdr_legal = (w_hdr_len == 16'd2);
                16'd1:   w_hdr_legal = (w_hdr_len == 16'd2);
                16'd2:   w_hdr_legal = (w_hdr_len == 16'd5);
                default: w_hdr_legal = 1'b0;
            endcase
        end
    end

    // Payload slot = len-1-remaining. Legal payloads are at most four words,
    // so modulo-4 arithmetic on the low bits gives the exact slot.
    assign w_slot = r_lenm1 - r_remaining[1:0];

    // Every dropped message is counted once, at its header.
    assign w_err_inc = (r_state == S_HDR) && w_accept && (w_hdr_short || !w_hdr_legal);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and call strobes. A call strobe is only raised when its
    // callee is ready, so a strobe always means the call fires this cycle.
    // Reset suppresses any pending call in the cycle it is asserted.
    always_comb begin
        w_next     = r_state;
        o_say_ena  = 1'b0;
        o_say2_ena = 1'b0;
        o_say4_ena = 1'b0;
        case (r_state)
            S_HDR: begin
                if (w_accept && !w_hdr_short) begin
                    w_next = w_hdr_legal ? S_PAY : S_DRAIN;
                end
            end
            S_PAY: begin
                if (w_accept && (r_remaining == 16'd1)) begin
                    w_next = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                case (r_id)
                    ID_SAY: begin
                        o_say_ena = i_say_rdy & ~i_rst;
                        if (i_say_rdy) w_next = S_HDR;
                    end
                    ID_SAY2: begin
                        o_say2_ena = i_say2_rdy & ~i_rst;
                        if (i_say2_rdy) w_next = S_HDR;
                    end
                    ID_SAY4: begin
                        o_say4_ena = i_say4_rdy & ~i_rst;
                        if (i_say4_rdy) w_next = S_HDR;
                    end
                    default: w_next = S_HDR;
                endcase
            end
            S_DRAIN: begin
                if (w_accept && (r_remaining == 16'd1)) begin
                    w_next = S_HDR;
                end
            end
            default: w_next = S_HDR;
        endcase
    end

    // Message bookkeeping: method id, word counter, payload capture and the
    // saturating drop counter. The drain counter is a full 16 bits so any
    // advertised length can be skipped regardless of MAX_WORDS.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_id        <= 2'd0;
            r_lenm1     <= 2'd0;
            r_remaining <= 16'd0;
            r_err       <= '0;
            for (int i = 0; i < 4; i++) begin
                r_pay[i] <= 32'd0;
            end
        end else begin
            if (w_err_inc && (r_err != {ERR_W{1'b1}})) begin
                r_err <= r_err + ERR_W'(1);
            end
            case (r_state)
                S_HDR: begin
                    if (w_accept && !w_hdr_short) begin
                        r_remaining <= w_hdr_lenm1;
                        if (w_hdr_legal) begin
                            r_id    <= w_hdr_id[1:0];
                            r_lenm1 <= w_hdr_lenm1[1:0];
                        end
                    end
                end
                S_PAY: begin
                    if (w_accept) begin
                        r_pay[w_slot] <= i_pipe_enq_v;
                        r_remaining   <= r_remaining - 16'd1;
                    end
                end
                S_DRAIN: begin
                    if (w_accept) begin
                        r_remaining <= r_remaining - 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_say_v     = r_pay[0];
    assign o_say2_a    = r_pay[0][31:16];
    assign o_say2_b    = r_pay[0][15:0];
    assign o_say4_a    = r_pay[0];
    assign o_say4_b    = r_pay[1];
    assign o_say4_c    = r_pay[2];
    assign o_say4_d    = r_pay[3];
    assign o_err_count = r_err;

endmodule

// File: tb/tb_p2m_echo_request_deser.sv
// -----------------------------------------------------------------------------
// tb_p2m_echo_request_deser
//
// Purpose:
//   Self-checking bench for p2m_echo_request_deser. Expected method calls
//   are pushed onto a scoreboard queue as messages are sent and popped by a
//   monitor whenever a call strobe is seen. A table of message vectors
//   covers the basic decode; hand-written sequences cover backpressure,
//   latency, error accounting, saturation and reset mid-message.
// -----------------------------------------------------------------------------
module tb_p2m_echo_request_deser;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipeEna;
    logic [31:0] pipeV;
    logic        pipeRdy;
    logic        sayEna;
    logic [31:0] sayV;
    logic        sayRdy;
    logic        say2Ena;
    logic [15:0] say2A;
    logic [15:0] say2B;
    logic        say2Rdy;
    logic        say4Ena;
    logic [31:0] say4A;
    logic [31:0] say4B;
    logic [31:0] say4C;
    logic [31:0] say4D;
    logic        say4Rdy;
    logic [7:0]  errCount;

    p2m_echo_request_deser #(.MAX_WORDS(8), .ERR_W(8)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_pipe_enq_ena (pipeEna),
        .i_pipe_enq_v   (pipeV),
        .o_pipe_enq_rdy (pipeRdy),
        .o_say_ena      (sayEna),
        .o_say_v        (sayV),
        .i_say_rdy      (sayRdy),
        .o_say2_ena     (say2Ena),
        .o_say2_a       (say2A),
        .o_say2_b       (say2B),
        .i_say2_rdy     (say2Rdy),
        .o_say4_ena     (say4Ena),
        .o_say4_a       (say4A),
        .o_say4_b       (say4B),
        .o_say4_c       (say4C),
        .o_say4_d       (say4D),
        .i_say4_rdy     (say4Rdy),
        .o_err_count    (errCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
    } call_t;

    typedef struct packed {
        int               n;
        logic [9:0][31:0] w;
        logic             hasCall;
        call_t            call;
        int               errInc;
    } vec_t;

    call_t sb[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    lastAcceptCyc = 0;
    int    lastFireCyc = 0;
    int    fire4Cyc = 0;
    int    expErr = 0;

    // Edge counter used to measure call and accept latencies.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: any call strobe must be single, qualified by its ready, and
    // match the oldest expected call.
    always @(negedge clk) begin
        int    n;
        int    kind;
        call_t e;
        n = 0;
        if (sayEna)  n++;
        if (say2Ena) n++;
        if (say4Ena) n++;
        if (n > 0) begin
            checkOutput("single_ena", 32'(n), 32'd1);
            if (sayEna)  checkOutput("say_rdy_qual",  32'(sayRdy),  32'd1);
            if (say2Ena) checkOutput("say2_rdy_qual", 32'(say2Rdy), 32'd1);
            if (say4Ena) checkOutput("say4_rdy_qual", 32'(say4Rdy), 32'd1);
            lastFireCyc = cyc + 1;
            if (say4Ena) fire4Cyc = cyc + 1;
            kind = sayEna ? 0 : (say2Ena ? 1 : 2);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_call: got kind %0d expected no call", kind);
            end else begin
                e = sb.pop_front();
                checkOutput("call_kind", 32'(kind), 32'(e.kind));
                case (kind)
                    0: checkOutput("say_v", sayV, e.a);
                    1: begin
                        checkOutput("say2_a", 32'(say2A), e.a);
                        checkOutput("say2_b", 32'(say2B), e.b);
                    end
                    default: begin
                        checkOutput("say4_a", say4A, e.a);
                        checkOutput("say4_b", say4B, e.b);
                        checkOutput("say4_c", say4C, e.c);
                        checkOutput("say4_d", say4D, e.d);
                    end
                endcase
            end
        end
    end

    // Offer one word and hold it until the DUT accepts it (bounded).
    task automatic applyStimulus(input logic [31:0] w);
        int n;
        n = 0;
        @(negedge clk);
        pipeEna = 1'b1;
        pipeV   = w;
        while (!pipeRdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!pipeRdy) begin
            total++;
            bad++;
            $display("[TB] FAIL send_timeout: rdy 0 required 1");
            pipeEna = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            pipeEna = 1'b0;
            lastAcceptCyc = cyc;
        end
    endtask

    // Wait (bounded) for all expected calls to have fired.
    task automatic waitIdle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expErr = 0;
    endtask

    function automatic call_t mkCall(input logic [1:0] k, input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] c, input logic [31:0] d);
        call_t r;
        r.kind = k;
        r.a = a;
        r.b = b;
        r.c = c;
        r.d = d;
        return r;
    endfunction

    vec_t vecs[9];

    initial begin
        int payEnd;
        int hdrAcc;

        rst     = 1'b1;
        pipeEna = 1'b0;
        pipeV   = 32'd0;
        sayRdy  = 1'b1;
        say2Rdy = 1'b1;
        say4Rdy = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_rdy", 32'(pipeRdy), 32'd1);
        checkOutput("rst_ena", {29'd0, sayEna, say2Ena, say4Ena}, 32'd0);
        checkOutput("rst_args", sayV | say4B | say4C | say4D, 32'd0);
        checkOutput("rst_err", 32'(errCount), 32'd0);
        rst = 1'b0;

        // Message table: words, expected call, expected error increment.
        vecs = '{default: '0};
        vecs[0].n = 2; vecs[0].w[0] = 32'h0000_0002; vecs[0].w[1] = 32'hCAFE_F00D;
        vecs[0].hasCall = 1'b1; vecs[0].call = mkCall(2'd0, 32'hCAFE_F00D, 0, 0, 0);
        vecs[1].n = 2; vecs[1].w[0] = 32'h0001_0002; vecs[1].w[1] = 32'hABCD_0123;
        vecs[1].hasCall = 1'b1; vecs[1].call = mkCall(2'd1, 32'h0000_ABCD, 32'h0000_0123, 0, 0);
        vecs[2].n = 5; vecs[2].w[0] = 32'h0002_0005; vecs[2].w[1] = 32'h1111_1111;
        vecs[2].w[2] = 32'h2222_2222; vecs[2].w[3] = 32'h3333_3333; vecs[2].w[4] = 32'h4444_4444;
        vecs[2].hasCall = 1'b1;
        vecs[2].call = mkCall(2'd2, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
        vecs[3].n = 3; vecs[3].w[0] = 32'h0000_0003; vecs[3].w[1] = 32'h0000_0002; vecs[3].w[2] = 32'h0000_0005;
        vecs[3].errInc = 1;
        vecs[4].n = 2; vecs[4].w[0] = 32'h0002_0002; vecs[4].w[1] = 32'h0002_0005;
        vecs[4].errInc = 1;
        vecs[5].n = 9; vecs[5].w[0] = 32'h0000_0009;
        for (int j = 1; j < 9; j++) vecs[5].w[j] = 32'h0000_0002;
        vecs[5].errInc = 1;
        vecs[6].n = 1; vecs[6].w[0] = 32'h0000_0001; vecs[6].errInc = 1;
        vecs[7].n = 2; vecs[7].w[0] = 32'h0003_0002; vecs[7].w[1] = 32'h0000_0002; vecs[7].errInc = 1;
        vecs[8].n = 2; vecs[8].w[0] = 32'h0000_0002; vecs[8].w[1] = 32'h0000_0000;
        vecs[8].hasCall = 1'b1; vecs[8].call = mkCall(2'd0, 32'h0, 0, 0, 0);

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].hasCall) sb.push_back(vecs[i].call);
            for (int j = 0; j < vecs[i].n; j++) applyStimulus(vecs[i].w[j]);
            @(negedge clk);
            expErr += vecs[i].errInc;
            checkOutput($sformatf("err_vec%0d", i), 32'(errCount), 32'(expErr));
        end
        waitIdle();

        // say: call one cycle after the last payload word.
        sb.push_back(mkCall(2'd0, 32'hDEAD_BEEF, 0, 0, 0));
        applyStimulus(32'h0000_0002);
        applyStimulus(32'hDEAD_BEEF);
        waitIdle();
        checkOutput("say_latency", 32'(lastFireCyc - lastAcceptCyc), 32'd1);

        // say2 with callee backpressure; offered words are ignored meanwhile.
        say2Rdy = 1'b0;
        sb.push_back(mkCall(2'd1, 32'h0000_1234, 32'h0000_5678, 0, 0));
        applyStimulus(32'h0001_0002);
        applyStimulus(32'h1234_5678);
        repeat (5) begin
            @(negedge clk);
            pipeEna = 1'b1;
            pipeV   = 32'h0000_0001;
            checkOutput("bp_rdy_low", 32'(pipeRdy), 32'd0);
            checkOutput("bp_no_ena", 32'(say2Ena), 32'd0);
        end
        @(posedge clk);
        #1;
        pipeEna = 1'b0;
        say2Rdy = 1'b1;
        waitIdle();
        checkOutput("bp_err_same", 32'(errCount), 32'(expErr));

        // say4 back-to-back followed immediately by the next header.
        sb.push_back(mkCall(2'd2, 32'd1, 32'd2, 32'd3, 32'd4));
        applyStimulus(32'h0002_0005);
        applyStimulus(32'd1);
        applyStimulus(32'd2);
        applyStimulus(32'd3);
        applyStimulus(32'd4);
        payEnd = lastAcceptCyc;
        sb.push_back(mkCall(2'd0, 32'h0000_0055, 0, 0, 0));
        applyStimulus(32'h0000_0002);
        hdrAcc = lastAcceptCyc;
        applyStimulus(32'h0000_0055);
        waitIdle();
        checkOutput("say4_fire_lat", 32'(fire4Cyc - payEnd), 32'd1);
        checkOutput("say4_next_hdr", 32'(hdrAcc - fire4Cyc), 32'd1);

        // Error accounting from a clean counter.
        pulseReset();
        applyStimulus(32'h0007_0003);
        applyStimulus(32'h0000_0002);
        applyStimulus(32'h0002_0005);
        applyStimulus(32'h0000_0000);
        sb.push_back(mkCall(2'd0, 32'h0BAD_F00D, 0, 0, 0));
        applyStimulus(32'h0000_0002);
        applyStimulus(32'h0BAD_F00D);
        waitIdle();
        checkOutput("err_two", 32'(errCount), 32'd2);

        // Saturation.
        for (int i = 0; i < 260; i++) applyStimulus(32'h0000_0001);
        @(negedge clk);
        checkOutput("err_sat", 32'(errCount), 32'd255);

        // Reset during say4 payload: abandoned, nothing fires.
        applyStimulus(32'h0002_0005);
        applyStimulus(32'h0000_000A);
        applyStimulus(32'h0000_000B);
        pulseReset();
        @(negedge clk);
        checkOutput("rstpay_rdy", 32'(pipeRdy), 32'd1);
        checkOutput("rstpay_err", 32'(errCount), 32'd0);
        checkOutput("rstpay_arg", say4A, 32'd0);

        // Reset while a say call is pending: it must never fire.
        sayRdy = 1'b0;
        applyStimulus(32'h0000_0002);
        applyStimulus(32'h7777_7777);
        pulseReset();
        sayRdy = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("rstdisp_rdy", 32'(pipeRdy), 32'd1);

        // Recovery after reset.
        sb.push_back(mkCall(2'd0, 32'h1357_9BDF, 0, 0, 0));
        applyStimulus(32'h0000_0002);
        applyStimulus(32'h1357_9BDF);
        waitIdle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
